// File: rtl/bus_pkg.sv
// Shared definitions for the single-wire bus frame format, used by both the
// transmitter and the receiver of the 16-node network.
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRC,
        ST_DST,
        ST_MOD,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_WAIT_IDLE
    } bus_state_e;

    localparam int SRC_W = 4;
    localparam int DST_W = 4;
    localparam int MOD_W = 2;
    localparam int CRC_W = 4;

    localparam logic [CRC_W-1:0] CRC_POLY   = 4'h3;
    localparam logic [3:0]       BCAST_ADDR = 4'hF;

    // Payload length in bits selected by the two-bit size code.
    function automatic logic [6:0] payload_len(input logic [MOD_W-1:0] mod);
        logic [6:0] len;
        case (mod)
            2'b00:   len = 7'd8;
            2'b01:   len = 7'd16;
            2'b10:   len = 7'd32;
            default: len = 7'd64;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 (x^4 + x + 1, init 0), one bit per enabled clock.
// Shared between the bus transmitter and receiver.
module crc4_serial
    import bus_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             feedback;

    always_comb begin
        feedback = bit_in ^ crc_q[CRC_W-1];
        crc_d    = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/bus_frame_receiver.sv
// Receive end of the shared bus: deserialises one frame bit per clock, filters
// on destination address, verifies the CRC and holds good payloads for the node.
module bus_frame_receiver
    import bus_pkg::*;
#(
    parameter logic [3:0] NODE_ADDR  = 4'd1,
    parameter logic [3:0] BCAST_ADDR = bus_pkg::BCAST_ADDR
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bus_in,
    input  logic        rx_ready,
    output logic        rx_valid,
    output logic [63:0] rx_data,
    output logic [3:0]  rx_src,
    output logic [1:0]  rx_mod,
    output logic        crc_err,
    output logic        frame_err,
    output logic        overflow
);

    localparam int CNT_W = 6;

    bus_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lastBit;

    logic [SRC_W-1:0]   src_q;
    logic [DST_W-2:0]   dstLow_q;
    logic [MOD_W-1:0]   mod_q;
    logic [63:0]        data_q;
    logic [CRC_W-1:0]   crcRx_q;
    logic               match_q;

    logic               rxValid_q;
    logic [63:0]        rxData_q;
    logic [SRC_W-1:0]   rxSrc_q;
    logic [MOD_W-1:0]   rxMod_q;
    logic               crcErr_q;
    logic               frameErr_q;
    logic               overflow_q;

    logic [CRC_W-1:0]   crcCalc;
    logic [DST_W-1:0]   dstFull;
    logic [MOD_W-1:0]   modFull;
    logic               crcClear;
    logic               crcEnable;
    logic               stopGood;
    logic               deliver;
    logic               dropFrame;
    logic               crcBad;
    logic               frameBad;

    assign lastBit = (cnt_q == '0);
    assign dstFull = {dstLow_q, bus_in};
    assign modFull = {mod_q[MOD_W-2:0], bus_in};

    crc4_serial u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (crcClear),
        .enable  (crcEnable),
        .bit_in  (bus_in),
        .crc     (crcCalc)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each field state counts down from its length - 1 and hands over at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus_in) begin
                    state_d = ST_SRC;
                    cnt_d   = CNT_W'(SRC_W - 1);
                end
            end
            ST_SRC: begin
                if (lastBit) begin
                    state_d = ST_DST;
                    cnt_d   = CNT_W'(DST_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DST: begin
                if (lastBit) begin
                    state_d = ST_MOD;
                    cnt_d   = CNT_W'(MOD_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_MOD: begin
                if (lastBit) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_W'(payload_len(modFull) - 7'd1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (lastBit) begin
                    state_d = ST_CRC;
                    cnt_d   = CNT_W'(CRC_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CRC: begin
                if (lastBit) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP:      state_d = bus_in ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (bus_in) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        crcClear  = (state_q == ST_IDLE) && !bus_in;
        crcEnable = (state_q == ST_SRC) || (state_q == ST_DST) ||
                    (state_q == ST_MOD) || (state_q == ST_DATA);
        stopGood  = (state_q == ST_STOP) && bus_in && match_q && (crcRx_q == crcCalc);
        deliver   = stopGood && (!rxValid_q || rx_ready);
        dropFrame = stopGood && rxValid_q && !rx_ready;
        crcBad    = (state_q == ST_STOP) && bus_in && match_q && (crcRx_q != crcCalc);
        frameBad  = (state_q == ST_STOP) && !bus_in;
    end

    // Field capture; a non-matching frame is still clocked through so the
    // next start bit lands on the right cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            src_q    <= '0;
            dstLow_q <= '0;
            mod_q    <= '0;
            data_q   <= '0;
            crcRx_q  <= '0;
            match_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus_in) begin
                        src_q    <= '0;
                        dstLow_q <= '0;
                        mod_q    <= '0;
                        data_q   <= '0;
                        crcRx_q  <= '0;
                        match_q  <= 1'b0;
                    end
                end
                ST_SRC:  src_q    <= {src_q[SRC_W-2:0], bus_in};
                ST_DST: begin
                    dstLow_q <= dstFull[DST_W-2:0];
                    if (lastBit) begin
                        match_q <= (dstFull == NODE_ADDR) || (dstFull == BCAST_ADDR);
                    end
                end
                ST_MOD:  mod_q    <= modFull;
                ST_DATA: data_q   <= {data_q[62:0], bus_in};
                ST_CRC:  crcRx_q  <= {crcRx_q[CRC_W-2:0], bus_in};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rxValid_q  <= 1'b0;
            rxData_q   <= '0;
            rxSrc_q    <= '0;
            rxMod_q    <= '0;
            crcErr_q   <= 1'b0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (deliver) begin
                rxValid_q <= 1'b1;
                rxData_q  <= data_q;
                rxSrc_q   <= src_q;
                rxMod_q   <= mod_q;
            end else if (rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end
            crcErr_q   <= crcBad;
            frameErr_q <= frameBad;
            overflow_q <= dropFrame;
        end
    end

    assign rx_valid  = rxValid_q;
    assign rx_data   = rxData_q;
    assign rx_src    = rxSrc_q;
    assign rx_mod    = rxMod_q;
    assign crc_err   = crcErr_q;
    assign frame_err = frameErr_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Self-checking bench for bus_frame_receiver: frames are built from their
// fields, and a frame-level model predicts every output cycle by cycle.
module tb_bus_frame_receiver;

    localparam logic [3:0] NODE = 4'd1;
    localparam logic [3:0] BCST = 4'hF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        bus_in;
    logic        rx_ready;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic [3:0]  rx_src;
    logic [1:0]  rx_mod;
    logic        crc_err;
    logic        frame_err;
    logic        overflow;

    int nChecks = 0;
    int nPass   = 0;
    bit checkEn = 1'b0;

    // Frame currently completing, published by the driver for the model.
    bit          stopNow   = 1'b0;
    logic        stopBitN  = 1'b1;
    bit          frmMatch  = 1'b0;
    bit          frmCrcOk  = 1'b0;
    logic [3:0]  frmSrc    = '0;
    logic [1:0]  frmMod    = '0;
    logic [63:0] frmData   = '0;

    logic        expValid    = 1'b0;
    logic [63:0] expData     = '0;
    logic [3:0]  expSrc      = '0;
    logic [1:0]  expMod      = '0;
    logic        expCrcErr   = 1'b0;
    logic        expFrameErr = 1'b0;
    logic        expOverflow = 1'b0;
    bit          mDelivered;

    bus_frame_receiver #(
        .NODE_ADDR  (NODE),
        .BCAST_ADDR (BCST)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_in    (bus_in),
        .rx_ready  (rx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_src    (rx_src),
        .rx_mod    (rx_mod),
        .crc_err   (crc_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    function automatic int payloadLen(input logic [1:0] mod);
        return 8 << mod;
    endfunction

    function automatic logic [3:0] crcOf(input logic [3:0] src, input logic [3:0] dst,
                                         input logic [1:0] mod, input logic [63:0] data);
        logic [3:0] c;
        logic [9:0] hdr;
        logic       b;
        logic       fb;
        int         len;
        c   = 4'h0;
        hdr = {src, dst, mod};
        len = payloadLen(mod);
        for (int i = 9 + len; i >= 0; i--) begin
            b  = (i >= len) ? hdr[i - len] : data[i];
            fb = b ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic applyStimulus(input logic b, input bit isStop);
        bus_in  = b;
        stopNow = isStop;
        @(posedge clock);
        #1;
        stopNow = 1'b0;
    endtask

    // Sends up to maxBits of a frame; forceCrc replaces the correct CRC field.
    task automatic sendFrame(input logic [3:0] src, input logic [3:0] dst, input logic [1:0] mod,
                             input logic [63:0] data, input bit forceCrc, input logic [3:0] crcVal,
                             input logic stopBit, input int maxBits);
        logic       bits[$];
        logic [63:0] d;
        logic [3:0] good;
        logic [3:0] crc;
        int         len;
        len  = payloadLen(mod);
        d    = (len == 64) ? data : (data & ((64'd1 << len) - 64'd1));
        good = crcOf(src, dst, mod, d);
        crc  = forceCrc ? crcVal : good;
        frmSrc   = src;
        frmMod   = mod;
        frmData  = d;
        frmMatch = (dst == NODE) || (dst == BCST);
        frmCrcOk = (crc == good);
        stopBitN = stopBit;
        bits.push_back(1'b0);
        for (int i = 3; i >= 0; i--) bits.push_back(src[i]);
        for (int i = 3; i >= 0; i--) bits.push_back(dst[i]);
        for (int i = 1; i >= 0; i--) bits.push_back(mod[i]);
        for (int i = len - 1; i >= 0; i--) bits.push_back(d[i]);
        for (int i = 3; i >= 0; i--) bits.push_back(crc[i]);
        bits.push_back(stopBit);
        for (int i = 0; i < bits.size() && i < maxBits; i++) begin
            applyStimulus(bits[i], i == bits.size() - 1);
        end
    endtask

    // Frame-level model: outcome decided once per completed frame.
    always @(posedge clock) begin
        if (!reset_n) begin
            expValid    = 1'b0;
            expData     = '0;
            expSrc      = '0;
            expMod      = '0;
            expCrcErr   = 1'b0;
            expFrameErr = 1'b0;
            expOverflow = 1'b0;
        end else begin
            mDelivered  = 1'b0;
            expCrcErr   = 1'b0;
            expFrameErr = 1'b0;
            expOverflow = 1'b0;
            if (stopNow) begin
                if (!stopBitN) begin
                    expFrameErr = 1'b1;
                end else if (frmMatch && !frmCrcOk) begin
                    expCrcErr = 1'b1;
                end else if (frmMatch) begin
                    if (!expValid || rx_ready) begin
                        expValid   = 1'b1;
                        expData    = frmData;
                        expSrc     = frmSrc;
                        expMod     = frmMod;
                        mDelivered = 1'b1;
                    end else begin
                        expOverflow = 1'b1;
                    end
                end
            end
            if (!mDelivered && expValid && rx_ready) expValid = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("rx_valid", rx_valid, expValid);
            checkOutput("crc_err", crc_err, expCrcErr);
            checkOutput("frame_err", frame_err, expFrameErr);
            checkOutput("overflow", overflow, expOverflow);
            if (expValid) begin
                checkOutput("rx_data", rx_data, expData);
                checkOutput("rx_src", rx_src, expSrc);
                checkOutput("rx_mod", rx_mod, expMod);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        bus_in   = 1'b1;
        rx_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkEn = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("reset_valid", rx_valid, 1'b0);
        checkOutput("reset_data", rx_data, 64'h0);
        checkOutput("reset_pulses", {crc_err, frame_err, overflow}, 3'b000);
        checkOutput("model_crc_f1", crcOf(4'd2, 4'd1, 2'b00, 64'h01), 4'h9);
        repeat (2) applyStimulus(1'b1, 1'b0);

        // Single 24-bit frame, held for 5 cycles, then released
        sendFrame(4'd2, 4'd1, 2'b00, 64'h01, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("f1_valid", rx_valid, 1'b1);
        checkOutput("f1_data", rx_data, 64'h1);
        checkOutput("f1_src", rx_src, 4'd2);
        checkOutput("f1_mod", rx_mod, 2'd0);
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("f1_hold_data", rx_data, 64'h1);
        rx_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);
        rx_ready = 1'b0;
        checkOutput("f1_released", rx_valid, 1'b0);

        // Bad CRC, foreign destination, broadcast
        sendFrame(4'd2, 4'd1, 2'b00, 64'h01, 1'b1, 4'h8, 1'b1, 99);
        @(negedge clock);
        checkOutput("badcrc_pulse", crc_err, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0);
        sendFrame(4'd2, 4'd3, 2'b00, 64'h01, 1'b0, 4'h0, 1'b1, 99);
        repeat (2) applyStimulus(1'b1, 1'b0);
        sendFrame(4'd2, 4'hF, 2'b00, 64'h01, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("bcast_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);

        // 64-bit frame followed immediately by a 32-bit frame
        sendFrame(4'd4, 4'd1, 2'b11, 64'hDEADBEEF_01234567, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("f64_data", rx_data, 64'hDEADBEEF_01234567);
        checkOutput("f64_mod", rx_mod, 2'd3);
        sendFrame(4'd5, 4'd1, 2'b10, 64'hA5A5_0F0F, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("f32_data", rx_data, 64'h0000_0000_A5A5_0F0F);
        applyStimulus(1'b1, 1'b0);
        rx_ready = 1'b0;

        // Overflow: second good frame while the first is still held
        sendFrame(4'd3, 4'd1, 2'b00, 64'h55, 1'b0, 4'h0, 1'b1, 99);
        applyStimulus(1'b1, 1'b0);
        sendFrame(4'd4, 4'hF, 2'b01, 64'h1234, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("ovf_pulse", overflow, 1'b1);
        checkOutput("ovf_kept_data", rx_data, 64'h55);
        rx_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);

        // Framing errors (matching and foreign), bus held low afterwards
        sendFrame(4'd2, 4'd1, 2'b00, 64'h01, 1'b0, 4'h0, 1'b0, 99);
        @(negedge clock);
        checkOutput("ferr_pulse", frame_err, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        sendFrame(4'd6, 4'd1, 2'b01, 64'hBEEF, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("after_ferr_data", rx_data, 64'hBEEF);
        applyStimulus(1'b1, 1'b0);
        sendFrame(4'd2, 4'd7, 2'b00, 64'h33, 1'b0, 4'h0, 1'b0, 99);
        @(negedge clock);
        checkOutput("ferr_foreign", frame_err, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0);
        rx_ready = 1'b0;

        // Reset in the middle of DATA while a frame is held
        sendFrame(4'd7, 4'd1, 2'b00, 64'hC3, 1'b0, 4'h0, 1'b1, 99);
        applyStimulus(1'b1, 1'b0);
        sendFrame(4'd8, 4'd1, 2'b10, 64'h1234_5678, 1'b0, 4'h0, 1'b1, 16);
        bus_in  = 1'b1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_valid", rx_valid, 1'b0);
        checkOutput("rst_data", rx_data, 64'h0);
        checkOutput("rst_src_mod", {rx_src, rx_mod}, 6'h0);
        applyStimulus(1'b1, 1'b0);
        sendFrame(4'd9, 4'd1, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b0, 4'h0, 1'b1, 99);
        @(negedge clock);
        checkOutput("post_rst_data", rx_data, 64'h0123_4567_89AB_CDEF);
        checkOutput("post_rst_src", rx_src, 4'd9);
        rx_ready = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bus_frame_receiver.md
Name: bus_frame_receiver

Overview:
- Receive end of the single-wire shared `bus` used by the 16-node FPGA network.
- Samples one bit per `clock` and deserialises the frame produced by a node's transmitter.
- Checks the destination address against its own node address and verifies the 4-bit CRC.
- Presents accepted payloads on a valid/ready interface to the node's local logic.

Parameters:
- NODE_ADDR, 4'd1, address this instance answers to.
- BCAST_ADDR, 4'hF, broadcast destination accepted by every node.

Ports:
- clock  in  1  system clock; one bus bit per rising edge.
- reset_n  in  1  synchronous, active-low reset.
- bus_in  in  1  sampled bus line; idle level 1.
- rx_ready  in  1  consumer accepts the held frame.
- rx_valid  out  1  frame held and available.
- rx_data  out  64  payload, right-aligned, upper bits zero.
- rx_src  out  4  sender address.
- rx_mod  out  2  payload size code of the held frame.
- crc_err  out  1  one-cycle pulse: addressed frame failed CRC.
- frame_err  out  1  one-cycle pulse: stop bit was 0.
- overflow  out  1  one-cycle pulse: good frame dropped because holding register busy.

Behaviour:
- Interface: one clock `clock`; reset is synchronous and active-low (`reset_n`).
- Frame, MSB first, one bit per clock: start(0), src[3:0], dst[3:0], mod[1:0], data (mod 00=8, 01=16, 10=32, 11=64 bits), crc[3:0], stop(1).
  - Minimum frame is 24 bits; maximum is 80 bits.
- CRC: CRC-4, x^4+x+1, init 0.
  - Computed over src, dst, mod and data bits.
  - Serial update: fb = bit ^ c[3]; c = {c[2:0],1'b0} ^ (fb ? 4'h3 : 4'h0).
  - The received crc field must equal c.
- States:
  - IDLE: bus_in=0 -> SRC; clear the bit counter, CRC and shift register.
  - SRC (4 bits) -> DST (4) -> MOD (2) -> DATA (8/16/32/64 per latched mod) -> CRC (4) -> STOP (1).
  - A single down-counter is loaded with each field's length - 1; move to the next state when it reaches 0.
- Addressing:
  - Match is dst==NODE_ADDR or dst==BCAST_ADDR, evaluated at the end of DST.
  - On a mismatch, keep tracking the frame to STOP so framing stays aligned, but suppress all outputs for that frame.
- STOP state, sample bus_in:
  - bus_in=1, match, CRC ok, rx_valid=0 -> load rx_data/rx_src/rx_mod; rx_valid=1 the next cycle (latency 1 after the stop bit).
  - bus_in=1, match, CRC ok, rx_valid=1 and rx_ready=0 in that cycle -> overflow pulse; the new frame is dropped and the held frame is kept.
  - bus_in=1, match, CRC ok, rx_valid=1 and rx_ready=1 in the same cycle -> accept the new frame; no overflow.
  - bus_in=1, match, CRC bad -> crc_err pulse; nothing delivered.
  - bus_in=0 -> frame_err pulse, then WAIT_IDLE; stay there until bus_in=1, then IDLE.
    - No crc_err for this frame; frame_err has priority.
    - frame_err fires even on an address mismatch.
  - All STOP-state cases return to IDLE; back-to-back frames may start on the very next cycle.
- Handshake:
  - rx_valid stays high, with rx_data/rx_src/rx_mod stable, until a cycle with rx_ready=1.
  - rx_valid drops the cycle after that handshake.
  - rx_ready while rx_valid=0 is ignored.
- Reset:
  - reset_n=0 at any clock edge forces state IDLE.
  - All outputs return to 0: rx_valid, rx_data, rx_src, rx_mod, crc_err, frame_err, overflow.
  - Any in-progress frame is discarded.
  - After reset, a bus held at 0 is treated as a start bit.
- Widths:
  - The data shift register is 64 bits, shifting left with the new bit in at [0].
  - Short payloads are therefore right-aligned with zero upper bits; no masking is needed.

Decomposition:
- Shared package bus_pkg holds:
  - state enum;
  - field widths SRC_W=4, DST_W=4, MOD_W=2, CRC_W=4;
  - CRC_POLY=4'h3;
  - BCAST_ADDR;
  - a function mapping mod to payload length.
- The transmitter uses the same package.
- One sub-module, crc4_serial (clock, reset_n, clear, enable, bit_in, crc[3:0]), shared with the transmitter.

Test Plan:
- Single frame: src=2, dst=1, mod=00, data=8'h01, crc=4'h9 (24 bits) -> rx_valid one cycle after the stop bit, rx_data=64'h1, rx_src=2, rx_mod=0; hold rx_ready=0 for 5 cycles -> outputs stable; pulse rx_ready -> rx_valid=0 next cycle.
- Same frame with crc=4'h8 -> crc_err single pulse, rx_valid stays 0; same frame with dst=3 -> no outputs at all; dst=4'hF with the correct CRC -> delivered.
- 64-bit frame, mod=11, data=64'hDEADBEEF_01234567, CRC from the model -> rx_data exact, rx_mod=3; then a 32-bit frame back-to-back with no idle gap -> both delivered when rx_ready=1 throughout.
- Two valid frames with rx_ready=0 -> first held, overflow pulses at the second's stop bit, rx_data still the first frame's payload.
- Stop bit forced to 0, bus then held 0 for 10 cycles -> frame_err pulse, no new frame start until the bus returns to 1.
- reset_n=0 for 1 cycle mid-DATA, then a full valid frame -> all outputs 0 after reset, the partial frame is discarded, the following frame is received correctly.
